// File: rtl/order_uart_tx.sv
// order_uart_tx: sends a 5-byte order frame (A5, side/qty, price hi, price lo, xor) as 8N1 UART.
// Fields are captured on the accepting edge; Transmit while busy is dropped and flagged.
module order_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic        Transmit,
  input  logic        SIDE,
  input  logic [6:0]  QTY,
  input  logic [15:0] PRICE,
  output logic        UART_TXD,
  output logic        BUSY,
  output logic        DONE,
  output logic        DROPPED
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic side_q, side_d;
  logic [6:0] qty_q, qty_d;
  logic [15:0] price_q, price_d;
  logic txd_q, txd_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;
  logic [7:0] b1, cur;
  logic tick;
  assign b1 = {side_q, qty_q};
  assign cur = byte_q == 3'd0 ? 8'hA5 :
               byte_q == 3'd1 ? b1 :
               byte_q == 3'd2 ? price_q[15:8] :
               byte_q == 3'd3 ? price_q[7:0] :
               b1 ^ price_q[15:8] ^ price_q[7:0];
  assign tick = baud_q == LAST;
  always_comb begin
    state_d = state_q;
    baud_d  = tick ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    side_d  = side_q;
    qty_d   = qty_q;
    price_d = price_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = Transmit && state_q != IDLE;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (Transmit) begin
          state_d = START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          byte_d  = 3'd0;
          side_d  = SIDE;
          qty_d   = QTY;
          price_d = PRICE;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
        txd_d   = cur[0];
      end
      DATA: if (tick) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d   = bit_q + 3'd1;
        txd_d   = bit_q == 3'd7 ? 1'b1 : cur[bit_q + 3'd1];
      end
      STOP: if (tick) begin
        // last stop bit of the checksum byte closes the frame
        state_d = byte_q == 3'd4 ? IDLE : START;
        byte_d  = byte_q == 3'd4 ? 3'd0 : byte_q + 3'd1;
        txd_d   = byte_q == 3'd4;
        busy_d  = byte_q != 3'd4;
        done_d  = byte_q == 3'd4;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      side_q  <= 1'b0;
      qty_q   <= 7'd0;
      price_q <= 16'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      side_q  <= side_d;
      qty_q   <= qty_d;
      price_q <= price_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end
  assign UART_TXD = txd_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DROPPED  = drop_q;
endmodule

// File: tb/tb_order_uart_tx.sv
// tb_order_uart_tx: scoreboard bench; stimulus pushes expected bytes/DONE/DROPPED cycles,
// monitors decode the serial line and output pulses and compare against the queues.
module tb_order_uart_tx;
  localparam int N = 4;
  localparam int FRAME = 50 * N;
  logic CLK = 1'b0, CPU_RESETN = 1'b1, Transmit = 1'b0, SIDE = 1'b0;
  logic [6:0] QTY = 7'd0;
  logic [15:0] PRICE = 16'd0;
  logic UART_TXD, BUSY, DONE, DROPPED;
  int checks = 0, errors = 0, cyc = 0, last_acc = -1000;
  logic [7:0] exp_q[$];
  int done_q[$];
  int drop_q[$];

  order_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .Transmit(Transmit), .SIDE(SIDE),
    .QTY(QTY), .PRICE(PRICE), .UART_TXD(UART_TXD), .BUSY(BUSY),
    .DONE(DONE), .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an edge is accepted iff it comes after the edge that ends the
  // previous frame; accepted edges enqueue the whole frame and its DONE cycle.
  task automatic drive(input logic t, input logic s, input logic [6:0] q, input logic [15:0] p);
    logic [7:0] b1;
    int e;
    @(posedge CLK);
    #1;
    Transmit = t; SIDE = s; QTY = q; PRICE = p;
    e = cyc + 1;
    b1 = {s, q};
    if (t) begin
      if (e > last_acc + FRAME) begin
        last_acc = e;
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        exp_q.push_back(b1 ^ p[15:8] ^ p[7:0]);
        done_q.push_back(e + FRAME);
      end else drop_q.push_back(e);
    end
  endtask

  task automatic tick();
    drive(1'b0, SIDE, QTY, PRICE);
  endtask

  task automatic wait_idle(input bit noisy);
    while (cyc + 1 <= last_acc + FRAME) begin
      if (noisy) drive($urandom_range(0, 19) == 0, 1'($urandom), 7'($urandom), 16'($urandom));
      else tick();
    end
  endtask

  initial begin : byte_mon
    logic s [40];
    logic [7:0] b;
    logic ok, abort;
    forever begin
      @(negedge CLK);
      if (CPU_RESETN === 1'b1 && UART_TXD === 1'b0) begin
        s[0] = 1'b0;
        abort = 1'b0;
        for (int i = 1; i < 40 && !abort; i++) begin
          @(negedge CLK);
          if (CPU_RESETN !== 1'b1) abort = 1'b1;
          else s[i] = UART_TXD;
        end
        if (!abort) begin
          ok = 1'b1;
          for (int j = 0; j < 4; j++) if (s[j] !== 1'b0 || s[36+j] !== 1'b1) ok = 1'b0;
          for (int k = 0; k < 8; k++) begin
            b[k] = s[4+4*k];
            for (int j = 1; j < 4; j++) if (s[4+4*k+j] !== s[4+4*k]) ok = 1'b0;
          end
          check("bit_framing", ok, 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_byte: got 0x%0h, expected no byte", b);
          end else check("frame_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : pulse_mon
    logic busy_prev;
    int busy_start;
    busy_prev = 1'b0;
    busy_start = 0;
    forever begin
      @(negedge CLK);
      if (CPU_RESETN !== 1'b1) busy_prev = 1'b0;
      else begin
        if (BUSY === 1'b1 && !busy_prev) busy_start = cyc;
        if (BUSY === 1'b0 && busy_prev) check("busy_len", cyc - busy_start, FRAME);
        busy_prev = BUSY === 1'b1;
        if (DONE === 1'b1) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done: got DONE at cycle %0d, expected none", cyc);
          end else check("done_cycle", cyc, done_q.pop_front());
        end
        if (DROPPED === 1'b1) begin
          if (drop_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_dropped: got DROPPED at cycle %0d, expected none", cyc);
          end else check("dropped_cycle", cyc, drop_q.pop_front());
        end
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int e0;
    logic s;
    logic [6:0] q;
    logic [15:0] p;
    #2 CPU_RESETN = 1'b0;
    #1;
    check("rst_txd", UART_TXD, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_dropped", DROPPED, 0);
    repeat (3) tick();
    CPU_RESETN = 1'b1;
    repeat (3) tick();
    drive(1'b1, 1'b1, 7'h05, 16'h1234);
    tick();
    wait_idle(1'b0);
    repeat (4) tick();
    drive(1'b1, 1'b0, 7'h11, 16'h4321);
    e0 = last_acc;
    tick();
    while (cyc + 1 < e0 + 50) tick();
    drive(1'b1, 1'b1, 7'h7F, 16'hFFFF);
    while (cyc + 1 < e0 + FRAME) tick();
    drive(1'b1, 1'b0, 7'h7F, 16'h00FF);
    drive(1'b1, 1'b0, 7'h7F, 16'h00FF);
    check("back_to_back_accept", last_acc, e0 + FRAME + 1);
    tick();
    wait_idle(1'b0);
    repeat (2) tick();
    drive(1'b1, 1'b1, 7'h2A, 16'hA55A);
    drive(1'b0, 1'b1, 7'h2A, 16'hFFFF);
    wait_idle(1'b0);
    repeat (2) tick();
    repeat (3) drive(1'b1, 1'b0, 7'h40, 16'h0102);
    tick();
    wait_idle(1'b0);
    repeat (2) tick();
    drive(1'b1, 1'b1, 7'h05, 16'h1234);
    e0 = last_acc;
    tick();
    while (cyc < e0 + 97) tick();
    check("line_before_reset", UART_TXD, 0);
    CPU_RESETN = 1'b0;
    #1;
    check("midreset_txd", UART_TXD, 1);
    check("midreset_busy", BUSY, 0);
    exp_q.delete();
    done_q.delete();
    last_acc = -1000;
    repeat (3) tick();
    CPU_RESETN = 1'b1;
    drive(1'b1, 1'b0, 7'h33, 16'hBEEF);
    tick();
    wait_idle(1'b0);
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      s = 1'($urandom);
      q = 7'($urandom);
      p = 16'($urandom);
      repeat ($urandom_range(1, 2)) drive(1'b1, s, q, p);
      wait_idle(1'b1);
    end
    repeat (6) tick();
    check("bytes_outstanding", exp_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);
    check("dropped_outstanding", drop_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
